// File: rtl/enc_pkg.sv
// Shared types and helpers for the 16-to-4 sequential request encoder.
// Optional feature macro used by the encoder: ENC_ROUND_ROBIN_EN.
package enc_pkg;

  localparam int N     = 16;
  localparam int IDX_W = $clog2(N);

  typedef logic [N-1:0]     req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;
  // Wide enough to count every request line (0..N).
  typedef logic [IDX_W:0]   pop_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } enc_state_t;

  // One-hot vector with only bit 'idx' set; the decoder's view of an index.
  function automatic req_vec_t onehot(input idx_t idx);
    req_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Number of set bits in a request vector.
  function automatic pop_t popcount(input req_vec_t v);
    pop_t c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + pop_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/req_encoder_16to4_if.sv
// Valid/ready offer channel between the encoder (master) and its consumer (slave).
interface req_encoder_16to4_if;
  import enc_pkg::*;

  logic out_valid;
  logic out_ready;
  idx_t out_idx;

  modport master (
    output out_valid,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    output out_ready
  );

endinterface

// File: rtl/prio_enc16.sv
// Combinational 16-line priority encoder with a movable starting point.
// The search begins at 'start' and walks downward, wrapping from 0 to 15;
// start=15 gives plain fixed priority (bit 15 highest, bit 0 lowest).
module prio_enc16
  import enc_pkg::*;
(
  input  req_vec_t vec,
  input  idx_t     start,
  output idx_t     idx,
  output logic     any
);

  idx_t pos;

  // Scan from lowest to highest priority so the last hit (nearest to start) wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    idx = start;
    pos = start;
    for (int k = N - 1; k >= 0; k--) begin
      pos = start - idx_t'(k);
      if (vec[pos]) begin
        idx = pos;
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/req_encoder_16to4.sv
// Sequential 16-to-4 priority encoder: latches request pulses into a pending
// register and offers the highest-priority pending index over valid/ready.
// Merged (already-pending) requests set a sticky ovf flag and are counted in a
// saturating drop counter.
// Optional feature macro: ENC_ROUND_ROBIN_EN (rotating search start pointer).
module req_encoder_16to4
  import enc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  req_vec_t                  req,
  input  logic                      ovf_clr,
  req_encoder_16to4_if.master       out_if,
  output req_vec_t                  pending,
  output logic                      ovf,
  output logic [CNT_W-1:0]          drop_cnt
);

  enc_state_t       state_q, state_d;
  req_vec_t         pending_q, pending_d;
  req_vec_t         clr, drops;
  idx_t             out_idx_q, out_idx_d;
  idx_t             start, sel_idx;
  logic             sel_any;
  logic             accept;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, cnt_base;
  logic [CNT_W:0]   drop_sum;
  pop_t             drop_pop;

  assign accept = (state_q == OFFER) & out_if.out_ready;

  // Retire the accepted index and merge new requests; a same-edge request re-sets the bit.
  always_comb begin
    clr       = accept ? onehot(out_idx_q) : '0;
    drops     = req & pending_q & ~clr;
    pending_d = (pending_q & ~clr) | req;
  end

`ifdef ENC_ROUND_ROBIN_EN
  idx_t ptr_q, ptr_d;

  // After accepting index i, start the next search just below i so i becomes lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = out_idx_q - idx_t'(1);
    end
  end

  // Rotating pointer register; reset value 15 matches fixed priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // The selection made on an accept edge already uses the rotated pointer.
  assign start = ptr_d;
`else
  assign start = '1;
`endif

  // Select the next index from the post-update pending vector.
  prio_enc16 u_prio (
    .vec   (pending_d),
    .start (start),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave IDLE when anything is pending, return once the last one is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_any)             state_d = OFFER;
      OFFER:   if (accept && !sel_any)  state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // FSM output: load a new index when starting an offer or after an accept; otherwise hold it stable.
  always_comb begin
    out_idx_d = out_idx_q;
    case (state_q)
      IDLE:    if (sel_any)            out_idx_d = sel_idx;
      OFFER:   if (accept && sel_any)  out_idx_d = sel_idx;
      default:                         out_idx_d = out_idx_q;
    endcase
  end

  // Overflow flag and saturating drop count; a drop on the clear edge survives the clear.
  always_comb begin
    drop_pop   = popcount(drops);
    cnt_base   = ovf_clr ? '0 : drop_cnt_q;
    drop_sum   = {1'b0, cnt_base} + (CNT_W + 1)'(drop_pop);
    drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    ovf_d      = (ovf_q & ~ovf_clr) | (|drops);
  end

  // Datapath registers: pending vector, offered index, overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      out_idx_q  <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      out_idx_q  <= out_idx_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_if.out_valid = (state_q == OFFER);
  assign out_if.out_idx   = out_idx_q;
  assign pending          = pending_q;
  assign ovf              = ovf_q;
  assign drop_cnt         = drop_cnt_q;

endmodule
